// File: rtl/axi_write_arbiter.sv
// Two-requester AXI4-Lite write arbiter: grants one requester, runs a single AW/W/B
// transaction and returns a one-cycle DONE pulse. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module axi_write_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [1:0]  REQ,
  input  logic [63:0] REQ_ADDR,
  input  logic [63:0] REQ_WDATA,
  input  logic [7:0]  REQ_WSTRB,
  output logic [1:0]  DONE,
  output logic [1:0]  DONE_RESP,
  output logic [31:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  output logic        BREADY,
  input  logic        BVALID,
  input  logic        BRESP
);

  typedef enum logic [1:0] {IDLE, XFER, RESP, CPL} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        gnt_reg, gnt_next, gnt_sel;
  logic [31:0] awaddr_reg, awaddr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic        awvalid_reg, awvalid_next;
  logic        wvalid_reg, wvalid_next;
  logic        bready_reg, bready_next;
  logic        status_reg, status_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        aw_fin, w_fin;

  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_addr[gi]  = REQ_ADDR[32*gi +: 32];
      assign req_wdata[gi] = REQ_WDATA[32*gi +: 32];
      assign req_wstrb[gi] = REQ_WSTRB[4*gi +: 4];
      assign DONE[gi]      = (state_reg == CPL) && (gnt_reg == 1'(gi));
      assign DONE_RESP[gi] = DONE[gi] & status_reg;
    end
  endgenerate

`ifdef ARB_ROUND_ROBIN_EN
  // prio_reg names the requester that wins the next contended grant.
  logic prio_reg, prio_next;

  always_comb begin
    gnt_sel   = (REQ == 2'b11) ? prio_reg : REQ[1];
    prio_next = prio_reg;
    if (state_reg == IDLE && REQ != 2'b00) begin
      prio_next = ~gnt_sel;
    end
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      prio_reg <= 1'b0;
    end else begin
      prio_reg <= prio_next;
    end
  end
`else
  assign gnt_sel = ~REQ[0];
`endif

  // A channel is finished once its VALID is low or its handshake happens this edge.
  assign aw_fin = !awvalid_reg || AWREADY;
  assign w_fin  = !wvalid_reg || WREADY;

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    awaddr_next  = awaddr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    bready_next  = bready_reg;
    status_next  = status_reg;
    cnt_next     = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (REQ != 2'b00) begin
          gnt_next     = gnt_sel;
          awaddr_next  = req_addr[gnt_sel];
          wdata_next   = req_wdata[gnt_sel];
          wstrb_next   = req_wstrb[gnt_sel];
          awvalid_next = 1'b1;
          wvalid_next  = 1'b1;
          state_next   = XFER;
        end
      end

      XFER: begin
        if (awvalid_reg && AWREADY) begin
          awvalid_next = 1'b0;
        end
        if (wvalid_reg && WREADY) begin
          wvalid_next = 1'b0;
        end
        if (aw_fin && w_fin) begin
          bready_next = 1'b1;
          cnt_next    = 8'd0;
          state_next  = RESP;
        end
      end

      RESP: begin
        // A response arriving on the timeout cycle wins over the forced error.
        if (BVALID) begin
          status_next = BRESP;
          bready_next = 1'b0;
          state_next  = CPL;
        end else if (cnt_reg == CNT_LAST) begin
          status_next = 1'b1;
          bready_next = 1'b0;
          state_next  = CPL;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      CPL: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_reg   <= IDLE;
      gnt_reg     <= 1'b0;
      awaddr_reg  <= 32'd0;
      wdata_reg   <= 32'd0;
      wstrb_reg   <= 4'd0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      status_reg  <= 1'b0;
      cnt_reg     <= 8'd0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      awaddr_reg  <= awaddr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
      status_reg  <= status_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign AWADDR  = awaddr_reg;
  assign AWVALID = awvalid_reg;
  assign WDATA   = wdata_reg;
  assign WSTRB   = wstrb_reg;
  assign WVALID  = wvalid_reg;
  assign BREADY  = bready_reg;

endmodule

// File: doc/axi_write_arbiter.md
AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 Parameter SHALL be: TIMEOUT, 16, number of cycles the arbiter waits in RESP for BVALID before it forces an error completion (legal range 2..255).
REQ-002 ACLK  input  1  the single clock; all logic is on its rising edge.
REQ-003 ARESET  input  1  asynchronous, active-low reset.
REQ-004 REQ  input  2  per-requester write request; bit n belongs to requester n.
REQ-005 REQ_ADDR  input  64  requester n byte address in bits [32n+31:32n].
REQ-006 REQ_WDATA  input  64  requester n write data in bits [32n+31:32n].
REQ-007 REQ_WSTRB  input  8  requester n byte strobes in bits [4n+3:4n].
REQ-008 DONE  output  2  one-cycle completion pulse to requester n.
REQ-009 DONE_RESP  output  2  completion status for requester n, valid with DONE[n] (0 OKAY, 1 error).
REQ-010 AWADDR/AWVALID  output  32/1  AXI write-address channel driven to the slave; AWREADY input 1.
REQ-011 WDATA/WSTRB/WVALID  output  32/4/1  AXI write-data channel; WREADY input 1.
REQ-012 BREADY  output  1  AXI response ready; BVALID input 1; BRESP input 1 (0 OKAY, 1 error).

Function
REQ-013 The FSM SHALL have the states IDLE, XFER, RESP and CPL, with one transaction outstanding at most.
REQ-014 In IDLE with any REQ bit high, the arbiter SHALL grant one requester and register its address, data and strobes, then enter XFER on the next edge.
REQ-015 A REQ bit that drops before the grant SHALL be ignored; dropping REQ after the grant SHALL NOT abort the transaction.
REQ-016 In XFER the arbiter SHALL assert AWVALID and WVALID together in the first XFER cycle (one cycle after the grant).
REQ-017 AWADDR, WDATA and WSTRB SHALL remain stable while their VALID is high.
REQ-018 Each VALID SHALL drop the cycle after its own READY is sampled high; the two channels SHALL complete independently, in either order or on the same edge.
REQ-019 The arbiter SHALL leave XFER for RESP on the edge where both channels have completed.
REQ-020 In RESP the arbiter SHALL hold BREADY=1 and, on BVALID&BREADY, capture BRESP and enter CPL.
REQ-021 A timeout counter SHALL clear on RESP entry and increment once per RESP cycle.
REQ-022 When the counter reaches TIMEOUT-1 with BVALID low, the arbiter SHALL enter CPL with status 1.
REQ-023 If BVALID arrives on the same cycle as the timeout, the BVALID handshake SHALL take priority and the captured BRESP SHALL be the status.
REQ-024 In CPL the arbiter SHALL pulse DONE[g] for exactly one cycle with DONE_RESP[g]=status, where g is the granted requester, and SHALL return to IDLE.
REQ-025 A new grant SHALL be possible on the cycle after CPL, giving a minimum of 4 cycles per transaction.
REQ-026 The address SHALL pass through unmodified, with no alignment check; a strobe of 4'b0000 SHALL still run a complete AXI transaction.

Reset
REQ-027 While ARESET=0, the outputs AWVALID, WVALID, BREADY, DONE and DONE_RESP SHALL be 0.
REQ-028 While ARESET=0, AWADDR, WDATA and WSTRB SHALL be 0, the state SHALL be IDLE and the timeout counter SHALL be 0.
REQ-029 While ARESET=0, the round-robin pointer SHALL be set so that requester 0 wins the first contended grant.
REQ-030 A reset during XFER, RESP or CPL SHALL abandon the transaction with no DONE pulse.
REQ-031 The first grant SHALL be possible on the first rising edge after ARESET deasserts.

Configuration
REQ-032 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last, and the pointer SHALL update at every grant.
REQ-033 Without ARB_ROUND_ROBIN_EN, requester 0 SHALL always win simultaneous requests, and the pointer logic SHALL be absent.

Verification
REQ-034 REQ=01, addr 0x4, data 0xAABBCCDD, strb 0xF; slave AWREADY/WREADY immediate, BVALID 1 cycle later with BRESP=0 -> exactly one AW and one W beat, DONE=01 and DONE_RESP=00 in cycle 5.
REQ-035 The slave raises WREADY 3 cycles before AWREADY -> WVALID drops first, AWVALID is held with AWADDR stable, and there is a single DONE after B.
REQ-036 REQ=11 held for 4 transactions with ARB_ROUND_ROBIN_EN -> grants 0,1,0,1; without the macro -> grants 0,0,0,0.
REQ-037 BVALID is never asserted, TIMEOUT=16 -> BREADY is high for 16 cycles, then DONE[g]=1 and DONE_RESP[g]=1, and the FSM is back in IDLE.
REQ-038 ARESET pulsed low during RESP -> all outputs are 0 immediately, no DONE pulse, and a fresh REQ=10 then completes normally.
